// File: rtl/video_pkg.sv
// Shared types and helpers for the video line tracker.
package video_pkg;

  localparam int X_W_DEF = 12;
  localparam int Y_W_DEF = 12;

  // Frame-tracking states: IDLE discards a partial frame after reset,
  // SYNC waits for the start of vs, ACTIVE counts lines.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Increment that sticks at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max;
    max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Polarity-normalises one sync input and flags entry/exit of its active level.
module sync_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic act,
  output logic rise,
  output logic fall
);

  logic q;

  assign act = (din == POL);

  // One-cycle history of the active level for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) q <= 1'b0;
    else        q <= act;
  end

  assign rise = act & ~q;
  assign fall = ~act & q;

endmodule

// File: rtl/video_line_tracker.sv
// Line/pixel position tracker for the capture front end: band-wrapped line
// index, pixel index, band/frame counters and line/frame measurements.
module video_line_tracker
  import video_pkg::*;
#(
  parameter int   X_W        = X_W_DEF,
  parameter int   Y_W        = Y_W_DEF,
  parameter int   BAND_LINES = 45,
  parameter int   BAND_W     = 8,
  parameter int   FRM_W      = 16,
  parameter logic VS_POL     = 1'b1,
  parameter logic HS_POL     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs,
  input  logic              hs,
  input  logic              de,
  output logic [Y_W-1:0]    yaddr,
  output logic [X_W-1:0]    xaddr,
  output logic              h_add_flag,
  output logic              band_wrap,
  output logic [BAND_W-1:0] band_cnt,
  output logic [X_W-1:0]    line_len,
  output logic [Y_W-1:0]    frame_lines,
  output logic [FRM_W-1:0]  frame_cnt,
  output logic              locked
);

  localparam logic [2:0]     SYNC_POL = {1'b1, HS_POL, VS_POL};
  localparam logic [Y_W-1:0] BAND_Y   = Y_W'(BAND_LINES);

  // Lanes: 0 = vs, 1 = hs, 2 = de.
  logic [2:0] sync_in, sync_act, sync_rise, sync_fall;

  assign sync_in = {de, hs, vs};

  for (genvar i = 0; i < 3; i++) begin : g_det
    sync_edge_det #(.POL(SYNC_POL[i])) u_det (
      .clk  (clk),
      .reset(reset),
      .din  (sync_in[i]),
      .act  (sync_act[i]),
      .rise (sync_rise[i]),
      .fall (sync_fall[i])
    );
  end

  logic vs_a, vs_rise, vs_fall, hs_edge, de_a, de_rise, de_fall;

  assign vs_a    = sync_act[0];
  assign vs_rise = sync_rise[0];
  assign vs_fall = sync_fall[0];
  assign hs_edge = sync_rise[1];
  assign de_a    = sync_act[2];
  assign de_rise = sync_rise[2];
  assign de_fall = sync_fall[2];

  state_t         state_q, state_d;
  logic           frame_end;
  logic [Y_W-1:0] line_total, line_total_d, yaddr_d;
  logic           wrap_d;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; frame_end marks the vs release that closes a frame.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE:   if (!vs_a) state_d = SYNC;
      SYNC:   if (vs_rise) state_d = ACTIVE;
      ACTIVE: if (vs_fall) begin
        state_d   = SYNC;
        frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next line index / line count; losing vs wins over a coincident hs edge.
  always_comb begin
    yaddr_d      = yaddr;
    line_total_d = line_total;
    wrap_d       = 1'b0;
    if (state_q != ACTIVE || !vs_a) begin
      yaddr_d      = '0;
      line_total_d = '0;
    end else if (hs_edge) begin
      line_total_d = Y_W'(sat_inc(32'(line_total), Y_W));
      if (BAND_LINES != 0 && yaddr == BAND_Y) begin
        yaddr_d = Y_W'(1);
        wrap_d  = 1'b1;
      end else begin
        yaddr_d = Y_W'(sat_inc(32'(yaddr), Y_W));
      end
    end
  end

  // Line index, line count and the pulses derived from their transitions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      yaddr      <= '0;
      line_total <= '0;
      band_wrap  <= 1'b0;
      h_add_flag <= 1'b0;
    end else begin
      yaddr      <= yaddr_d;
      line_total <= line_total_d;
      band_wrap  <= wrap_d;
      // Zero -> non-zero can only land on 1, so this pulses with yaddr==1.
      h_add_flag <= (yaddr == '0) && (yaddr_d != '0);
    end
  end

  // Band counter: restarts with each frame, counts wraps, sticks at max.
  always_ff @(posedge clk) begin
    if (!reset)      band_cnt <= '0;
    else if (vs_rise) band_cnt <= '0;
    else if (wrap_d)  band_cnt <= BAND_W'(sat_inc(32'(band_cnt), BAND_W));
  end

  // Pixel index within the current de run; FSM-independent.
  always_ff @(posedge clk) begin
    if (!reset)       xaddr <= '0;
    else if (de_rise) xaddr <= X_W'(1);
    else if (de_a)    xaddr <= X_W'(sat_inc(32'(xaddr), X_W));
    else              xaddr <= '0;
  end

  // Line length captured at the end of each de run inside a frame.
  always_ff @(posedge clk) begin
    if (!reset)                          line_len <= '0;
    else if (de_fall && state_q == ACTIVE) line_len <= xaddr;
  end

  // Frame statistics latched when the frame closes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_lines <= '0;
      frame_cnt   <= '0;
      locked      <= 1'b0;
    end else if (frame_end) begin
      frame_lines <= line_total;
      frame_cnt   <= frame_cnt + FRM_W'(1);
      locked      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_line_tracker.sv
// Directed bench: default instance (positive syncs, 45-line bands) plus a
// negative-polarity, no-wrap instance for saturation.
module tb_video_line_tracker;

  logic clk = 1'b0;
  logic reset;
  logic vs, hs, de;
  logic vs_b, hs_b, de_b;

  logic [11:0] yaddr, xaddr, line_len, frame_lines;
  logic        h_add_flag, band_wrap, locked;
  logic [7:0]  band_cnt;
  logic [15:0] frame_cnt;

  logic [11:0] yaddr_b, xaddr_b, line_len_b, frame_lines_b;
  logic        h_add_flag_b, band_wrap_b, locked_b;
  logic [7:0]  band_cnt_b;
  logic [15:0] frame_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  video_line_tracker dut_a (
    .clk(clk), .reset(reset), .vs(vs), .hs(hs), .de(de),
    .yaddr(yaddr), .xaddr(xaddr), .h_add_flag(h_add_flag), .band_wrap(band_wrap),
    .band_cnt(band_cnt), .line_len(line_len), .frame_lines(frame_lines),
    .frame_cnt(frame_cnt), .locked(locked)
  );

  video_line_tracker #(.BAND_LINES(0), .VS_POL(1'b0), .HS_POL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .vs(vs_b), .hs(hs_b), .de(de_b),
    .yaddr(yaddr_b), .xaddr(xaddr_b), .h_add_flag(h_add_flag_b), .band_wrap(band_wrap_b),
    .band_cnt(band_cnt_b), .line_len(line_len_b), .frame_lines(frame_lines_b),
    .frame_cnt(frame_cnt_b), .locked(locked_b)
  );

  typedef struct {
    logic        vs, hs, de;
    logic [11:0] y, x;
    logic        h, w;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic h, input logic d);
    vs = v; hs = h; de = d;
    tick();
  endtask

  task automatic hs_pulse(input logic d);
    drv(1'b1, 1'b1, d);
    drv(1'b1, 1'b0, d);
  endtask

  vec_t tbl[12];

  initial begin
    int errs, wraps, hadds;
    logic [11:0] exp_y;

    // vs, hs, de -> yaddr, xaddr, h_add_flag, band_wrap after the edge
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 12'd1, 12'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 12'd1, 12'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 12'd2, 12'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 12'd2, 12'd3, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 12'd3, 12'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 12'd3, 12'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 12'd4, 12'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 12'd4, 12'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 12'd5, 12'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 12'd5, 12'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};

    // dut_b idles with both syncs at their inactive (high) level
    vs_b = 1'b1; hs_b = 1'b1; de_b = 1'b0;

    // ---- 1: reset, a full frame, then reset mid-frame ----
    reset = 1'b0;
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    chk("rst_yaddr", yaddr, 0);
    chk("rst_locked", locked, 0);
    reset = 1'b1;
    drv(1'b0, 1'b0, 1'b0);               // IDLE -> SYNC
    drv(1'b1, 1'b0, 1'b0);               // vs rise -> ACTIVE
    repeat (3) hs_pulse(1'b0);
    chk("pre_yaddr", yaddr, 3);
    drv(1'b0, 1'b0, 1'b0);               // frame closes
    chk("pre_frame_lines", frame_lines, 3);
    chk("pre_frame_cnt", frame_cnt, 1);
    chk("pre_locked", locked, 1);
    drv(1'b1, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 1'b1);
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 1'b1);
    chk("mid_yaddr", yaddr, 2);
    chk("mid_xaddr", xaddr, 3);
    reset = 1'b0;
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 1'b1);
    drv(1'b1, 1'b0, 1'b1);
    chk("rst2_yaddr", yaddr, 0);
    chk("rst2_xaddr", xaddr, 0);
    chk("rst2_flags", {h_add_flag, band_wrap}, 0);
    chk("rst2_band_cnt", band_cnt, 0);
    chk("rst2_line_len", line_len, 0);
    chk("rst2_frame_lines", frame_lines, 0);
    chk("rst2_frame_cnt", frame_cnt, 0);
    chk("rst2_locked", locked, 0);
    reset = 1'b1;
    // Partial frame after reset must be ignored while IDLE.
    errs = 0;
    repeat (2) begin
      drv(1'b1, 1'b1, 1'b0);
      if (yaddr != 0 || h_add_flag) errs++;
      drv(1'b1, 1'b0, 1'b0);
      if (yaddr != 0 || h_add_flag) errs++;
    end
    chk("idle_ignores_partial", errs, 0);
    drv(1'b0, 1'b0, 1'b0);               // IDLE -> SYNC

    // ---- 2: table-driven 5-line frame ----
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].vs, tbl[i].hs, tbl[i].de);
      chk($sformatf("tbl%0d_yaddr", i), yaddr, tbl[i].y);
      chk($sformatf("tbl%0d_xaddr", i), xaddr, tbl[i].x);
      chk($sformatf("tbl%0d_hadd", i), h_add_flag, tbl[i].h);
      chk($sformatf("tbl%0d_wrap", i), band_wrap, tbl[i].w);
    end
    chk("t2_line_len", line_len, 3);
    chk("t2_frame_lines", frame_lines, 5);
    chk("t2_frame_cnt", frame_cnt, 1);
    chk("t2_locked", locked, 1);

    // ---- 3: 100 lines, two band wraps ----
    drv(1'b1, 1'b0, 1'b0);
    errs = 0; wraps = 0; hadds = 0;
    for (int k = 1; k <= 100; k++) begin
      drv(1'b1, 1'b1, 1'b0);
      exp_y = 12'(((k - 1) % 45) + 1);
      if (yaddr != exp_y) errs++;
      if (band_wrap != (k == 46 || k == 91)) errs++;
      if (h_add_flag != (k == 1)) errs++;
      wraps += int'(band_wrap);
      hadds += int'(h_add_flag);
      drv(1'b1, 1'b0, 1'b0);
      if (yaddr != exp_y || band_wrap || h_add_flag) errs++;
    end
    chk("t3_yaddr_seq", errs, 0);
    chk("t3_wrap_pulses", wraps, 2);
    chk("t3_hadd_pulses", hadds, 1);
    chk("t3_band_cnt", band_cnt, 2);
    chk("t3_last_yaddr", yaddr, 10);
    drv(1'b0, 1'b0, 1'b0);
    chk("t3_frame_lines", frame_lines, 100);
    chk("t3_frame_cnt", frame_cnt, 2);
    chk("t3_locked", locked, 1);
    chk("t3_band_cnt_hold", band_cnt, 2);

    // ---- 4: pixel index over 640- and 100-pixel lines ----
    drv(1'b1, 1'b0, 1'b0);
    chk("t4_band_cnt_clr", band_cnt, 0);
    hs_pulse(1'b0);
    vs = 1'b1; hs = 1'b0; de = 1'b1;
    errs = 0;
    for (int i = 0; i < 640; i++) begin
      if (xaddr != 12'(i)) errs++;
      tick();
    end
    chk("t4_xaddr_ramp640", errs, 0);
    drv(1'b1, 1'b0, 1'b0);
    chk("t4_xaddr_low", xaddr, 0);
    chk("t4_line_len640", line_len, 640);
    hs_pulse(1'b0);
    vs = 1'b1; hs = 1'b0; de = 1'b1;
    repeat (100) tick();
    drv(1'b1, 1'b0, 1'b0);
    chk("t4_line_len100", line_len, 100);
    hs_pulse(1'b0);
    chk("t4_yaddr", yaddr, 3);

    // ---- 5: hs edge coincident with vs drop ----
    drv(1'b0, 1'b1, 1'b0);
    chk("t5_yaddr", yaddr, 0);
    chk("t5_wrap", band_wrap, 0);
    chk("t5_hadd", h_add_flag, 0);
    chk("t5_frame_lines", frame_lines, 3);
    chk("t5_frame_cnt", frame_cnt, 3);
    drv(1'b0, 1'b0, 1'b0);

    // ---- 6: inverted polarity, no wrap, saturation (dut_b) ----
    vs_b = 1'b0; hs_b = 1'b1;            // vs active-low rises
    tick();
    errs = 0; wraps = 0; hadds = 0;
    for (int k = 1; k <= 4100; k++) begin
      hs_b = 1'b0;
      tick();
      exp_y = (k > 4095) ? 12'd4095 : 12'(k);
      if (yaddr_b != exp_y) errs++;
      wraps += int'(band_wrap_b);
      hadds += int'(h_add_flag_b);
      hs_b = 1'b1;
      tick();
      wraps += int'(band_wrap_b);
      hadds += int'(h_add_flag_b);
    end
    chk("t6_yaddr_sat_seq", errs, 0);
    chk("t6_yaddr_final", yaddr_b, 4095);
    chk("t6_no_wrap", wraps, 0);
    chk("t6_hadd_pulses", hadds, 1);
    vs_b = 1'b1;
    tick();
    chk("t6_frame_lines", frame_lines_b, 4095);
    chk("t6_frame_cnt", frame_cnt_b, 1);
    chk("t6_locked", locked_b, 1);
    chk("t6_band_cnt", band_cnt_b, 0);
    chk("t6_yaddr_end", yaddr_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_line_tracker.md
Name: video_line_tracker

Overview:
- Parametrised successor to the front-end line detector in the video capture path.
- Tracks line position within a frame from vs/hs/de and generates a line index that wraps over a configurable band height.
- Also tracks pixel position within a line, counts bands and frames, and measures line length and frame height.
- Outputs drive the downstream band-buffer write logic and the frame statistics registers.

Parameters:
X_W, 12, width of xaddr and line_len
Y_W, 12, width of yaddr, line_total and frame_lines
BAND_LINES, 45, line index wraps BAND_LINES -> 1; 0 = no wrap (yaddr saturates at all-ones)
BAND_W, 8, width of band_cnt
FRM_W, 16, width of frame_cnt
VS_POL, 1, active level of vs
HS_POL, 1, active level of hs (line advance on edge into active level)

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous active-low reset
vs  in  1  frame sync
hs  in  1  line sync
de  in  1  pixel data valid
yaddr  out  Y_W  line index within band (0 = no line yet this frame)
xaddr  out  X_W  pixel index within current de run
h_add_flag  out  1  1-cycle pulse: first line of frame started
band_wrap  out  1  1-cycle pulse: yaddr wrapped BAND_LINES -> 1
band_cnt  out  BAND_W  wraps completed this frame
line_len  out  X_W  de length of last completed line
frame_lines  out  Y_W  total hs edges of last completed frame
frame_cnt  out  FRM_W  completed frames, wraps modulo 2^FRM_W
locked  out  1  high once one full frame has been measured

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-low. While reset=0 at a rising edge, every register and output is cleared to 0 and the FSM goes to IDLE.
- Input polarity and edges:
  - vs_a = (vs == VS_POL); hs_a = (hs == HS_POL).
  - Each is registered once (vs_q, hs_q, de_q).
  - hs_edge = hs_a & ~hs_q. vs_rise = vs_a & ~vs_q. vs_fall = ~vs_a & vs_q.
- FSM:
  - IDLE: ignore input until vs_a=0, then go to SYNC. This discards a partial frame after reset.
  - SYNC: on vs_rise go to ACTIVE.
  - ACTIVE: on vs_fall go to SYNC and latch statistics.
- yaddr and line_total, in priority order:
  - (a) state != ACTIVE or vs_a=0 -> both are 0.
  - (b) hs_edge and BAND_LINES!=0 and yaddr==BAND_LINES -> yaddr=1, band_wrap=1 next cycle, band_cnt+1.
  - (c) hs_edge -> yaddr+1, saturating at all-ones when BAND_LINES=0.
  - line_total increments on every hs_edge in ACTIVE and saturates.
  - A vs drop in the same cycle as hs_edge resolves to (a).
- h_add_flag: high for exactly the one cycle in which yaddr is first non-zero after being 0. This is a registered compare of (yaddr!=0), so the pulse coincides with yaddr==1.
- band_wrap: high in the cycle yaddr shows 1 as a result of a wrap. It never coincides with h_add_flag.
- band_cnt: cleared on vs_rise; saturates at all-ones.
- xaddr:
  - de=1 -> xaddr+1 (saturate); de=0 -> 0.
  - During de, xaddr therefore equals the index of the previous pixel count: 0 on the first de cycle.
  - Independent of the FSM.
- line_len: latched with xaddr on de falling (~de & de_q) while state==ACTIVE.
- On vs_fall in ACTIVE:
  - frame_lines <= line_total
  - frame_cnt+1
  - locked <= 1
- Latency: all outputs are registered. yaddr changes one cycle after hs rises at the input pin.
- Reset mid-frame: all state is cleared. The tracker resyncs via IDLE, and no pulses are emitted for the partial frame.

Decomposition:
- Shared package video_pkg holds:
  - the FSM state enum (IDLE, SYNC, ACTIVE)
  - default widths X_W/Y_W
  - a sat_inc helper function
- One natural sub-module, sync_edge_det: registers one sync input with polarity and emits rise/fall pulses. Instantiate it three times (vs, hs, de).

Test Plan:
1. Reset low 3 cycles mid-frame, then vs inactive -> all outputs 0, FSM IDLE -> SYNC. No h_add_flag until the next vs_rise.
2. vs active, 5 hs pulses, BAND_LINES=45 -> yaddr 1..5. h_add_flag once, in the cycle yaddr=1. band_wrap never asserted.
3. 100 hs pulses in one frame, BAND_LINES=45 -> yaddr sequence 1..45,1..45,1..10. band_wrap pulses 2x. band_cnt=2. On vs_fall: frame_lines=100, frame_cnt=1, locked=1.
4. de high 640 cycles per line -> xaddr 0..639 during de. line_len=640 after the first de fall. xaddr=0 while de low.
5. hs_edge and vs drop in the same cycle -> yaddr=0, no band_wrap. Statistics latch line_total excluding that edge.
6. VS_POL=0, HS_POL=0, BAND_LINES=0, 4100 lines -> yaddr saturates at 4095 with no wrap. frame_lines=4095 (saturated).
